bist_scan_controller: RTL



---
 rtl/bist_scan_controller.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bist_scan_controller.sv
// BIST scan sequencer: LFSR pattern load, single-cycle capture, MISR compaction, golden compare.
// Optional abort input enabled by defining BIST_ABORT_EN.
module bist_scan_controller #(
  parameter int unsigned CHAIN_LEN    = 12,
  parameter int unsigned NUM_PATTERNS = 100,
  parameter int unsigned PI_W         = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
`ifdef BIST_ABORT_EN
  input  logic            abort,
`endif
  input  logic            scan_out_i,
  output logic            scan_en,
  output logic            scan_in_o,
  output logic [PI_W-1:0] pi_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [15:0]     signature
);

  localparam int unsigned ShiftW = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PatW   = $clog2(NUM_PATTERNS + 1);
  localparam logic [ShiftW-1:0] ShiftLast = ShiftW'(CHAIN_LEN - 1);
  localparam logic [PatW-1:0]   PatLast   = PatW'(NUM_PATTERNS - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StShift   = 3'd1;
  localparam logic [2:0] StCapture = 3'd2;
  localparam logic [2:0] StUnload  = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [15:0]       misr_q, misr_d;
  logic [ShiftW-1:0] shift_cnt_q, shift_cnt_d;
  logic [PatW-1:0]   pat_cnt_q, pat_cnt_d;
  logic [15:0]       lfsr_step, misr_step;
  logic              abort_req;
  logic              running;

`ifdef BIST_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign lfsr_step = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign misr_step = {misr_q[14:0], misr_q[15] ^ misr_q[13] ^ misr_q[12] ^ misr_q[10]}
                     ^ {15'b0, scan_out_i};
  assign running   = (state_q == StShift) || (state_q == StCapture) || (state_q == StUnload);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    shift_cnt_d = shift_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StShift;
          lfsr_d      = LFSR_SEED;
          misr_d      = '0;
          shift_cnt_d = '0;
          pat_cnt_d   = '0;
        end
      end
      StShift: begin
        lfsr_d      = lfsr_step;
        shift_cnt_d = shift_cnt_q + ShiftW'(1);
        // First load unloads reset-state chain contents; keep them out of the signature.
        if (pat_cnt_q != '0) misr_d = misr_step;
        if (shift_cnt_q == ShiftLast) begin
          shift_cnt_d = '0;
          state_d     = StCapture;
        end
      end
      StCapture: begin
        pat_cnt_d = pat_cnt_q + PatW'(1);
        state_d   = (pat_cnt_q == PatLast) ? StUnload : StShift;
      end
      StUnload: begin
        misr_d      = misr_step;
        shift_cnt_d = shift_cnt_q + ShiftW'(1);
        if (shift_cnt_q == ShiftLast) begin
          shift_cnt_d = '0;
          state_d     = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
    // Abort freezes every register except the state.
    if (abort_req && running) begin
      state_d     = StIdle;
      lfsr_d      = lfsr_q;
      misr_d      = misr_q;
      shift_cnt_d = shift_cnt_q;
      pat_cnt_d   = pat_cnt_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      lfsr_q      <= LFSR_SEED;
      misr_q      <= '0;
      shift_cnt_q <= '0;
      pat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      misr_q      <= misr_d;
      shift_cnt_q <= shift_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
    end
  end

  always_comb begin
    scan_en   = (state_q == StShift) || (state_q == StUnload);
    busy      = running;
    done      = (state_q == StDone);
    pass      = (state_q == StDone) && (misr_q == GOLDEN_SIG);
    scan_in_o = (state_q == StShift) ? lfsr_q[0] : 1'b0;
    pi_o      = (state_q == StCapture) ? lfsr_q[15 -: PI_W] : '0;
    signature = misr_q;
  end

endmodule
